// File: rtl/numeric_display_scan.sv
// Multiplexed N-digit seven-segment scanner.
// It decodes one hex nibble per digit and strobes one digit at a time. Brightness is
// set by PWM within each digit slot, and phase 0 of every slot is kept dark so the
// previous digit does not ghost. Leading zeros can be blanked. New values are applied
// only at the start of a frame, so a display update never tears.
module numeric_display_scan #(
  parameter int DIGIT_COUNT    = 4,
  parameter int CLK_DIV        = 10000,
  parameter int BRIGHT_BITS    = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                     MCLK,
  input  logic                     nRST,
  input  logic                     EN,
  input  logic                     LOAD,
  input  logic [4*DIGIT_COUNT-1:0] VALUE,
  input  logic [DIGIT_COUNT-1:0]   DP,
  input  logic                     BLANK_LZ,
  input  logic [BRIGHT_BITS-1:0]   BRIGHTNESS,
  output logic [7:0]               SEG_pins,
  output logic [DIGIT_COUNT-1:0]   DIGIT_pins,
  output logic                     FRAME_DONE
);

  // The slot tick is held as {phase, sub-phase}. Phase is then read directly,
  // with no divider, even when the phase length is not a power of two.
  localparam int PH_LEN = CLK_DIV >> BRIGHT_BITS;
  localparam int SUB_W  = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;
  localparam int IDX_W  = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;

  localparam logic [SUB_W-1:0]       SUB_MAX   = SUB_W'(PH_LEN - 1);
  localparam logic [IDX_W-1:0]       IDX_MAX   = IDX_W'(DIGIT_COUNT - 1);
  localparam logic [BRIGHT_BITS-1:0] PHASE_MAX = '1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  // Hex digit to segments {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [0:0]               state;
  logic [SUB_W-1:0]         sub_cnt;
  logic [BRIGHT_BITS-1:0]   phase;
  logic [IDX_W-1:0]         idx;

  logic [4*DIGIT_COUNT-1:0] pend_value, act_value, nxt_value;
  logic [DIGIT_COUNT-1:0]   pend_dp, act_dp, nxt_dp;
  logic                     pend_blz, act_blz, nxt_blz;

  logic                     slot_last, frame_last, scan_run;

  logic [3:0]               cur_nib;
  logic                     cur_dp, cur_blank;
  logic [DIGIT_COUNT-1:0]   lz_vec;

  logic [7:0]               seg_p0, seg_p1;
  logic [DIGIT_COUNT-1:0]   dig_p0, dig_p1;
  logic                     fd_p0, fd_p1;

  // A LOAD in the same cycle as a frame wrap is forwarded, so the newest value wins.
  assign nxt_value = LOAD ? VALUE    : pend_value;
  assign nxt_dp    = LOAD ? DP       : pend_dp;
  assign nxt_blz   = LOAD ? BLANK_LZ : pend_blz;

  assign slot_last  = (sub_cnt == SUB_MAX) && (phase == PHASE_MAX);
  assign frame_last = slot_last && (idx == IDX_MAX);
  assign scan_run   = (state == ST_SCAN) && EN;

  // Pending set: the last LOAD wins, in any state.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blz   <= 1'b0;
    end else if (LOAD) begin
      pend_value <= VALUE;
      pend_dp    <= DP;
      pend_blz   <= BLANK_LZ;
    end
  end

  // Scan FSM, slot counters, and the active set that is copied at each frame start.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_IDLE;
      sub_cnt   <= '0;
      phase     <= '0;
      idx       <= '0;
      act_value <= '0;
      act_dp    <= '0;
      act_blz   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          sub_cnt <= '0;
          phase   <= '0;
          idx     <= '0;
          if (EN) begin
            state     <= ST_SCAN;
            act_value <= nxt_value;
            act_dp    <= nxt_dp;
            act_blz   <= nxt_blz;
          end
        end
        ST_SCAN: begin
          if (!EN) begin
            state   <= ST_IDLE;
            sub_cnt <= '0;
            phase   <= '0;
            idx     <= '0;
          end else if (sub_cnt == SUB_MAX) begin
            sub_cnt <= '0;
            phase   <= phase + 1'b1;
            if (phase == PHASE_MAX) begin
              if (idx == IDX_MAX) begin
                idx       <= '0;
                act_value <= nxt_value;
                act_dp    <= nxt_dp;
                act_blz   <= nxt_blz;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end else begin
            sub_cnt <= sub_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Current digit selection and the leading-zero mask, scanned from the top digit down.
  always_comb begin
    logic lz_run;
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    lz_vec  = '0;
    lz_run  = 1'b1;
    for (int i = DIGIT_COUNT - 1; i >= 0; i--) begin
      if ((act_value[4*i +: 4] != 4'h0) || act_dp[i]) lz_run = 1'b0;
      lz_vec[i] = lz_run && (i != 0);
    end
    for (int i = 0; i < DIGIT_COUNT; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib = act_value[4*i +: 4];
        cur_dp  = act_dp[i];
      end
    end
    cur_blank = act_blz && lz_vec[idx];
  end

  // Stage 0: segment, strobe and frame-done values for the current counter state.
  always_comb begin
    seg_p0 = 8'h00;
    dig_p0 = '0;
    fd_p0  = 1'b0;
    if (scan_run) begin
      if (!cur_blank) seg_p0 = {cur_dp, seg7(cur_nib)};
      if ((phase != '0) && (phase <= BRIGHTNESS))
        dig_p0 = DIGIT_COUNT'(1) << idx;
      fd_p0 = frame_last;
    end
  end

  // Stage 1: registered outputs. Pin polarity is applied after the register.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      seg_p1 <= 8'h00;
      dig_p1 <= '0;
      fd_p1  <= 1'b0;
    end else begin
      seg_p1 <= seg_p0;
      dig_p1 <= dig_p0;
      fd_p1  <= fd_p0;
    end
  end

  assign SEG_pins   = (SEG_ACTIVE_LOW != 0) ? ~seg_p1 : seg_p1;
  assign DIGIT_pins = (DIG_ACTIVE_LOW != 0) ? ~dig_p1 : dig_p1;
  assign FRAME_DONE = fd_p1;

endmodule

// File: tb/tb_numeric_display_scan.sv
// Bench for numeric_display_scan. It has 4 digits, 32 clocks per slot and 16
// brightness phases. A cycle-count model predicts every pin on every cycle.
// Directed windows check slot-level properties with hand-computed values.
module tb_numeric_display_scan;

  localparam int DC = 4;
  localparam int CD = 32;
  localparam int BB = 4;

  logic          MCLK;
  logic          nRST;
  logic          EN;
  logic          LOAD;
  logic [15:0]   VALUE;
  logic [3:0]    DP;
  logic          BLANK_LZ;
  logic [3:0]    BRIGHTNESS;
  logic [7:0]    SEG_pins;
  logic [3:0]    DIGIT_pins;
  logic          FRAME_DONE;

  numeric_display_scan #(
    .DIGIT_COUNT(DC), .CLK_DIV(CD), .BRIGHT_BITS(BB),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)
  ) dut (
    .MCLK(MCLK), .nRST(nRST), .EN(EN), .LOAD(LOAD), .VALUE(VALUE), .DP(DP),
    .BLANK_LZ(BLANK_LZ), .BRIGHTNESS(BRIGHTNESS), .SEG_pins(SEG_pins),
    .DIGIT_pins(DIGIT_pins), .FRAME_DONE(FRAME_DONE)
  );

  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Segment shapes {g..a}, active-high.
  localparam logic [6:0] SEGTAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state. m_n counts the cycles since the scan started; tick and digit are derived from it.
  logic        m_scan;
  int          m_n;
  logic [15:0] m_pv, m_av;
  logic [3:0]  m_pd, m_ad;
  logic        m_pb, m_ab;
  logic [7:0]  e_seg;
  logic [3:0]  e_dig;
  logic        e_fd;

  always @(posedge MCLK or negedge nRST) begin
    logic [15:0] nv;
    logic [3:0]  nd;
    logic        nb, blank;
    int          t, d;
    if (!nRST) begin
      m_scan = 1'b0; m_n = 0;
      m_pv = '0; m_pd = '0; m_pb = 1'b0;
      m_av = '0; m_ad = '0; m_ab = 1'b0;
      e_seg = 8'hFF; e_dig = 4'h0; e_fd = 1'b0;
    end else begin
      nv = LOAD ? VALUE : m_pv;
      nd = LOAD ? DP : m_pd;
      nb = LOAD ? BLANK_LZ : m_pb;
      e_seg = 8'hFF; e_dig = 4'h0; e_fd = 1'b0;
      if (m_scan && EN) begin
        t = m_n % CD;
        d = (m_n / CD) % DC;
        blank = m_ab && (d != 0);
        for (int j = d; j < DC; j++)
          if (m_av[4*j +: 4] != 4'h0 || m_ad[j]) blank = 1'b0;
        if (!blank) e_seg = ~{m_ad[d], SEGTAB[m_av[4*d +: 4]]};
        if ((t / 2) >= 1 && (t / 2) <= int'(BRIGHTNESS)) e_dig = 4'b0001 << d;
        e_fd = (t == CD - 1) && (d == DC - 1);
        m_n++;
        if (m_n % (CD * DC) == 0) begin
          m_av = nv; m_ad = nd; m_ab = nb;
        end
      end else if (!m_scan && EN) begin
        m_scan = 1'b1; m_n = 0;
        m_av = nv; m_ad = nd; m_ab = nb;
      end else begin
        m_scan = 1'b0; m_n = 0;
      end
      m_pv = nv; m_pd = nd; m_pb = nb;
    end
  end

  // Compare every pin against the model on every falling edge.
  always @(negedge MCLK) begin
    if (chk_en) begin
      chk("model_seg", SEG_pins, e_seg);
      chk("model_digit", DIGIT_pins, e_dig);
      chk("model_frame_done", FRAME_DONE, e_fd);
    end
  end

  // Observation window summary.
  int         o_on, o_fd, o_first;
  logic [7:0] o_seg;
  logic       o_const;
  logic [3:0] o_or;

  task automatic observe(input int n);
    o_on = 0; o_fd = 0; o_first = -1; o_const = 1'b1; o_or = 4'h0; o_seg = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(negedge MCLK);
      if (i == 0) o_seg = SEG_pins;
      else if (SEG_pins !== o_seg) o_const = 1'b0;
      if (DIGIT_pins != 4'h0) begin
        o_on++;
        if (o_first < 0) o_first = i;
      end
      if (FRAME_DONE) o_fd++;
      o_or |= DIGIT_pins;
    end
  endtask

  task automatic slot_chk(input string name, input logic [7:0] seg, input logic [3:0] dig);
    chk({name, "_seg"}, o_seg, seg);
    chk({name, "_seg_steady"}, o_const, 1'b1);
    chk({name, "_strobe"}, o_or, dig);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; EN = 1'b0; LOAD = 1'b0; VALUE = '0; DP = '0;
    BLANK_LZ = 1'b0; BRIGHTNESS = '0;
    @(posedge MCLK); #1;
    chk("reset_seg", SEG_pins, 8'hFF);
    chk("reset_digit", DIGIT_pins, 4'h0);
    chk("reset_frame_done", FRAME_DONE, 1'b0);
    repeat (2) @(posedge MCLK);
    @(negedge MCLK);
    nRST = 1'b1;
    chk_en = 1'b1;

    // Idle for 100 cycles.
    observe(100);
    chk("idle_fd_count", o_fd, 0);
    chk("idle_strobes", o_or, 4'h0);
    slot_chk("idle", 8'hFF, 4'h0);

    // Basic scan of 12AF at full brightness.
    VALUE = 16'h12AF; LOAD = 1'b1; BRIGHTNESS = 4'd15;
    @(negedge MCLK);
    LOAD = 1'b0; EN = 1'b1;
    observe(1);
    chk("start_latency_strobe", o_or, 4'h0);
    observe(32);
    slot_chk("basic_d0", 8'h8E, 4'b0001);
    chk("basic_d0_on_cycles", o_on, 30);
    chk("basic_d0_first_on", o_first, 2);
    observe(32);
    slot_chk("basic_d1", 8'h88, 4'b0010);
    observe(64);
    chk("basic_fd_first_frame", o_fd, 1);
    observe(384);
    chk("basic_fd_three_frames", o_fd, 3);

    // Brightness 0 and 4.
    BRIGHTNESS = 4'd0;
    observe(128);
    chk("bright0_on_cycles", o_on, 0);
    BRIGHTNESS = 4'd4;
    observe(32);
    chk("bright4_on_cycles", o_on, 8);
    chk("bright4_first_on", o_first, 2);
    BRIGHTNESS = 4'd15;

    // Tear-free update: load during digit 2 of a frame.
    observe(32);
    VALUE = 16'h3456; LOAD = 1'b1;
    observe(1);
    LOAD = 1'b0;
    observe(31);
    slot_chk("tear_d2_old", 8'hA4, 4'b0100);
    observe(32);
    slot_chk("tear_d3_old", 8'hF9, 4'b1000);
    observe(32);
    slot_chk("tear_d0_new", 8'h82, 4'b0001);

    // Drop EN at digit 1, tick 10.
    observe(10);
    chk("pre_drop_strobe", o_or, 4'b0010);
    EN = 1'b0;
    observe(1);
    chk("drop_digit", o_or, 4'h0);
    chk("drop_seg", o_seg, 8'hFF);

    // Leading-zero blanking on 0050, with a restart from digit 0.
    VALUE = 16'h0050; DP = 4'b0000; BLANK_LZ = 1'b1; LOAD = 1'b1;
    observe(1);
    LOAD = 1'b0; EN = 1'b1;
    observe(1);
    observe(32);
    slot_chk("lz_d0", 8'hC0, 4'b0001);
    chk("restart_first_on", o_first, 2);
    observe(32);
    slot_chk("lz_d1", 8'h92, 4'b0010);
    observe(32);
    slot_chk("lz_d2", 8'hFF, 4'b0100);
    observe(31);
    slot_chk("lz_d3", 8'hFF, 4'b1000);
    // Load DP in the wrap cycle; the forwarded value takes effect in the next frame.
    DP = 4'b0100; LOAD = 1'b1;
    observe(1);
    chk("wrap_fd", o_fd, 1);
    LOAD = 1'b0;
    observe(32);
    slot_chk("lzdp_d0", 8'hC0, 4'b0001);
    observe(32);
    slot_chk("lzdp_d1", 8'h92, 4'b0010);
    observe(32);
    slot_chk("lzdp_d2", 8'h40, 4'b0100);
    observe(32);
    slot_chk("lzdp_d3", 8'hFF, 4'b1000);

    // Asynchronous reset in the middle of a slot.
    observe(10);
    chk("pre_reset_digit", DIGIT_pins, 4'b0001);
    #2 nRST = 1'b0;
    #1;
    chk("async_reset_seg", SEG_pins, 8'hFF);
    chk("async_reset_digit", DIGIT_pins, 4'h0);
    chk("async_reset_frame_done", FRAME_DONE, 1'b0);
    @(negedge MCLK);
    nRST = 1'b1;
    observe(140);
    chk("post_reset_fd", o_fd, 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
